// File: rtl/uart_tx_fifo_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_feeder_if
//
// Bundles the producer-side and transmitter-side signals of the UART TX FIFO
// feeder so they travel as a single port.
//
//   Wr_Data     [7:0]      byte to enqueue
//   Wr_En                  enqueue strobe
//   Flush                  discard all queued bytes
//   Tx_Ready               transmitter idle (no active frame)
//   Tx_Data     [7:0]      byte presented to the transmitter
//   Enable                 one-cycle launch pulse
//   Full / Empty           FIFO occupancy flags
//   Count       [ADDR_W:0] FIFO occupancy, 0..DEPTH
//   Busy                   sequencer not idle
//   Timeout_Err            sticky "transmitter never went busy" flag
//
// Modports:
//   slave  - the feeder itself
//   master - whatever drives the feeder (producers plus transmitter)
// -----------------------------------------------------------------------------
interface uart_tx_fifo_feeder_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      Wr_Data;
    logic            Wr_En;
    logic            Flush;
    logic            Tx_Ready;
    logic [7:0]      Tx_Data;
    logic            Enable;
    logic            Full;
    logic            Empty;
    logic [ADDR_W:0] Count;
    logic            Busy;
    logic            Timeout_Err;

    modport slave (
        input  Wr_Data, Wr_En, Flush, Tx_Ready,
        output Tx_Data, Enable, Full, Empty, Count, Busy, Timeout_Err
    );

    modport master (
        output Wr_Data, Wr_En, Flush, Tx_Ready,
        input  Tx_Data, Enable, Full, Empty, Count, Busy, Timeout_Err
    );
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_feeder
//
// Byte FIFO plus launch sequencer placed directly in front of the UART
// transmitter. Producers push bytes at system-clock rate; the sequencer pops
// one byte at a time, presents it on Tx_Data, pulses Enable for one cycle and
// then follows Tx_Ready through the frame so that a byte is never launched
// into an active transmission.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active high
//   bus  - uart_tx_fifo_feeder_if.slave (see interface file for signals)
//
// Parameters:
//   DEPTH        - FIFO entries, power of two, >= 2
//   ADDR_W       - log2(DEPTH)
//   BUSY_TIMEOUT - cycles allowed for Tx_Ready to fall after Enable
// -----------------------------------------------------------------------------
module uart_tx_fifo_feeder #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_fifo_feeder_if.slave   bus
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int TO_W  = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              full_q,      full_d;
    logic              empty_q,     empty_d;
    logic [7:0]        tx_data_q,   tx_data_d;
    logic              enable_q,    enable_d;
    logic              busy_q,      busy_d;
    logic              to_err_q,    to_err_d;
    logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;

    logic [7:0]        mem [DEPTH];

    logic              pop;
    logic              wr_accept;

    // -------------------------------------------------------------------------
    // Launch sequencer
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned; a missing default here would infer a latch.
        state_d  = state_q;
        pop      = 1'b0;
        to_cnt_d = to_cnt_q;
        to_err_d = to_err_q;

        unique case (state_q)
            S_IDLE: begin
                // Only pop when the transmitter is idle, so the byte can be
                // launched without waiting and a pending baud change in the
                // wrapper is never caught mid-frame.
                if (!empty_q && bus.Tx_Ready) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                // Tx_Data became valid on entry. Holding here while Tx_Ready
                // is low keeps Enable from ever landing on a busy transmitter.
                if (bus.Tx_Ready) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_BUSY;
            end

            S_WAIT_BUSY: begin
                if (!bus.Tx_Ready) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    // The transmitter never acknowledged the launch: flag it
                    // and give up on this byte so the queue keeps draining.
                    if (to_cnt_d == TO_LAST) begin
                        to_err_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end

            S_WAIT_DONE: begin
                if (bus.Tx_Ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO bookkeeping and registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // A pop in the same cycle frees a slot, so a write into a full FIFO is
        // still taken. Flush wins over any write.
        wr_accept = bus.Wr_En && !bus.Flush && (!full_q || pop);

        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;

        // The popped byte is captured even if Flush arrives in the same cycle;
        // it is already committed to the transmitter.
        if (pop) begin
            tx_data_d = mem[rd_ptr_q];
        end

        if (bus.Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            unique case ({wr_accept, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Flags are derived from the next count so they are registered
        // alongside Count and always agree with it.
        full_d   = (count_d == CNT_FULL);
        empty_d  = (count_d == '0);

        enable_d = (state_d == S_START);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            tx_data_q <= '0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            to_err_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            tx_data_q <= tx_data_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            to_err_q  <= to_err_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // Count define which entries are valid, and leaving the array out of reset
    // lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= bus.Wr_Data;
        end
    end

    assign bus.Tx_Data     = tx_data_q;
    assign bus.Enable      = enable_q;
    assign bus.Full        = full_q;
    assign bus.Empty       = empty_q;
    assign bus.Count       = count_q;
    assign bus.Busy        = busy_q;
    assign bus.Timeout_Err = to_err_q;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_feeder
//
// Bench for uart_tx_fifo_feeder. Bytes the bench expects to be transmitted are
// queued when written; a transmitter model inside tick() pops and compares
// them whenever Enable is seen, and drops Tx_Ready for a programmable frame
// length (or never, to emulate a dead transmitter).
// All sampling and driving happens 1 time unit after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_feeder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = ADDR_W + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_fifo_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_fifo_feeder #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks     = 0;
    int         failures   = 0;
    logic [7:0] exp_q[$];
    int         enable_cnt = 0;
    logic [7:0] last_sent  = 8'h00;

    // Transmitter model controls
    int         tx_busy_len = 10;
    int         busy_left   = 0;
    bit         tx_force_low = 1'b0;
    bit         tx_dead      = 1'b0;

    // Advance one cycle and run the transmitter model on the falling edge.
    task automatic tick();
        logic [7:0] exp;
        @(negedge clk);
        if (bus.Enable === 1'b1) begin
            enable_cnt++;
            checks++;
            if (bus.Tx_Ready !== 1'b1) begin
                failures++;
                $display("FAIL enable_while_busy tx_ready=%b required=1", bus.Tx_Ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL tx_byte got=%02h required=none", bus.Tx_Data);
            end else begin
                exp = exp_q.pop_front();
                if (bus.Tx_Data !== exp) begin
                    failures++;
                    $display("FAIL tx_byte got=%02h required=%02h", bus.Tx_Data, exp);
                end
            end
            last_sent = bus.Tx_Data;
            if (!tx_dead) busy_left = tx_busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        bus.Tx_Ready = !(tx_force_low || busy_left > 0);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] data, input bit expect_sent);
        bus.Wr_Data = data;
        bus.Wr_En   = 1'b1;
        if (expect_sent) exp_q.push_back(data);
        tick();
        bus.Wr_En   = 1'b0;
    endtask

    // Wait until everything expected has been sent and the sequencer is idle.
    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && bus.Busy === 1'b0 && bus.Tx_Ready === 1'b1) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_drain pending=%0d busy=%b required pending=0 busy=0", name, exp_q.size(), bus.Busy);
        end
    endtask

    // Returns the number of ticks until Enable is observed (0 if already high).
    task automatic wait_enable(input int budget, input string name, output int n);
        n = 0;
        while (bus.Enable !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_enable_wait got=no_enable required=enable within %0d", name, budget);
        end
    endtask

    task automatic wait_ready_high(input int budget, input string name);
        int n = 0;
        while (bus.Tx_Ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_ready_wait got=low required=high within %0d", name, budget);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.Tx_Data !== 8'h00 || bus.Enable !== 1'b0 || bus.Busy !== 1'b0 ||
            bus.Timeout_Err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got tx_data=%02h en=%b busy=%b err=%b required 00/0/0/0",
                     bus.Tx_Data, bus.Enable, bus.Busy, bus.Timeout_Err);
        end
        checks++;
        if (bus.Full !== 1'b0 || bus.Empty !== 1'b1 || bus.Count !== CNT_W'(0)) begin
            failures++;
            $display("FAIL reset_fifo got full=%b empty=%b count=%0d required 0/1/0",
                     bus.Full, bus.Empty, bus.Count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        tx_busy_len = 10;
        push_byte(8'hA5, 1'b1);
        checks++;
        if (bus.Count !== CNT_W'(1) || bus.Empty !== 1'b0) begin
            failures++;
            $display("FAIL single_count_after_write got count=%0d empty=%b required 1/0", bus.Count, bus.Empty);
        end
        wait_enable(20, "single", n);
        // Enable seen on the 3rd sample after the write was driven.
        checks++;
        if (n + 1 != 3) begin
            failures++;
            $display("FAIL single_latency got=%0d required=3", n + 1);
        end
        tick();
        checks++;
        if (bus.Enable !== 1'b0 || bus.Count !== CNT_W'(0) || bus.Empty !== 1'b1) begin
            failures++;
            $display("FAIL single_after_launch got en=%b count=%0d empty=%b required 0/0/1",
                     bus.Enable, bus.Count, bus.Empty);
        end
        wait_ready_high(40, "single");
        checks++;
        if (bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_at_ready got=%b required=1", bus.Busy);
        end
        tick();
        checks++;
        if (bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_after_ready got=%b required=0", bus.Busy);
        end
        wait_idle(50, "single");
    endtask

    task automatic test_back_to_back();
        int n;
        push_byte(8'h3C, 1'b1);
        push_byte(8'h3D, 1'b1);
        wait_enable(20, "b2b_first", n);
        tick();
        wait_ready_high(40, "b2b");
        wait_enable(20, "b2b_second", n);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL b2b_gap got=%0d required=3", n);
        end
        wait_idle(60, "b2b");
    endtask

    task automatic test_full();
        int base;
        tx_force_low = 1'b1;
        tick();
        tick();
        base = enable_cnt;
        for (int i = 1; i <= 16; i++) begin
            push_byte(8'(i), 1'b1);
            if (i == 15) begin
                checks++;
                if (bus.Count !== CNT_W'(15) || bus.Full !== 1'b0) begin
                    failures++;
                    $display("FAIL full_at_15 got count=%0d full=%b required 15/0", bus.Count, bus.Full);
                end
            end
        end
        checks++;
        if (bus.Count !== CNT_W'(16) || bus.Full !== 1'b1 || bus.Empty !== 1'b0) begin
            failures++;
            $display("FAIL full_at_16 got count=%0d full=%b empty=%b required 16/1/0",
                     bus.Count, bus.Full, bus.Empty);
        end
        push_byte(8'hFF, 1'b0);
        checks++;
        if (bus.Count !== CNT_W'(16) || bus.Full !== 1'b1) begin
            failures++;
            $display("FAIL full_overflow got count=%0d full=%b required 16/1", bus.Count, bus.Full);
        end
        tx_force_low = 1'b0;
        wait_idle(1000, "full");
        checks++;
        if (enable_cnt - base != 16 || last_sent !== 8'h10) begin
            failures++;
            $display("FAIL full_drain got sent=%0d last=%02h required 16/10", enable_cnt - base, last_sent);
        end
    endtask

    task automatic test_wrap_full_pop();
        int base;
        base = enable_cnt;
        tx_force_low = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1'b1);
        // Ready rises on the next falling edge; the pop happens on the rising
        // edge right after, which is the same edge that takes this write.
        tx_force_low = 1'b0;
        tick();
        push_byte(8'hC3, 1'b1);
        checks++;
        if (bus.Count !== CNT_W'(16) || bus.Full !== 1'b1) begin
            failures++;
            $display("FAIL wrap_write_with_pop got count=%0d full=%b required 16/1", bus.Count, bus.Full);
        end
        wait_idle(1000, "wrap_a");
        checks++;
        if (last_sent !== 8'hC3) begin
            failures++;
            $display("FAIL wrap_last_byte got=%02h required=c3", last_sent);
        end
        for (int i = 0; i < 12; i++) push_byte(8'h40 + 8'(i), 1'b1);
        wait_idle(1000, "wrap_b");
        for (int i = 0; i < 11; i++) push_byte(8'h80 + 8'(i), 1'b1);
        wait_idle(1000, "wrap_c");
        checks++;
        if (enable_cnt - base != 40 || last_sent !== 8'h8A) begin
            failures++;
            $display("FAIL wrap_total got sent=%0d last=%02h required 40/8a", enable_cnt - base, last_sent);
        end
    endtask

    task automatic test_flush();
        int base;
        for (int i = 0; i < 6; i++) push_byte(8'h61 + 8'(i), 1'b1);
        checks++;
        if (bus.Count !== CNT_W'(5) || bus.Busy !== 1'b1 || bus.Tx_Ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_pre got count=%0d busy=%b ready=%b required 5/1/0",
                     bus.Count, bus.Busy, bus.Tx_Ready);
        end
        exp_q.delete();
        bus.Flush   = 1'b1;
        push_byte(8'hEE, 1'b0);
        bus.Flush   = 1'b0;
        checks++;
        if (bus.Count !== CNT_W'(0) || bus.Empty !== 1'b1 || bus.Full !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got count=%0d empty=%b full=%b required 0/1/0",
                     bus.Count, bus.Empty, bus.Full);
        end
        base = enable_cnt;
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (enable_cnt != base || bus.Busy !== 1'b0 || last_sent !== 8'h61) begin
            failures++;
            $display("FAIL flush_after got enables=%0d busy=%b last=%02h required 0/0/61",
                     enable_cnt - base, bus.Busy, last_sent);
        end
    endtask

    task automatic test_timeout();
        int n;
        tx_dead = 1'b1;
        push_byte(8'h71, 1'b1);
        push_byte(8'h72, 1'b1);
        wait_enable(20, "timeout", n);
        checks++;
        if (bus.Timeout_Err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pre got=%b required=0", bus.Timeout_Err);
        end
        n = 0;
        while (bus.Timeout_Err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL timeout_delay got=%0d required=16", n);
        end
        wait_idle(100, "timeout");
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.Timeout_Err !== 1'b1 || last_sent !== 8'h72) begin
            failures++;
            $display("FAIL timeout_sticky got err=%b last=%02h required 1/72", bus.Timeout_Err, last_sent);
        end
        tx_dead = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int n;
        int base;
        tx_busy_len = 30;
        push_byte(8'h81, 1'b1);
        wait_enable(20, "rst_mid", n);
        tick();
        push_byte(8'h82, 1'b0);
        push_byte(8'h83, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.Tx_Data !== 8'h00 || bus.Enable !== 1'b0 || bus.Busy !== 1'b0 ||
            bus.Timeout_Err !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got tx_data=%02h en=%b busy=%b err=%b required 00/0/0/0",
                     bus.Tx_Data, bus.Enable, bus.Busy, bus.Timeout_Err);
        end
        checks++;
        if (bus.Full !== 1'b0 || bus.Empty !== 1'b1 || bus.Count !== CNT_W'(0)) begin
            failures++;
            $display("FAIL rst_mid_fifo got full=%b empty=%b count=%0d required 0/1/0",
                     bus.Full, bus.Empty, bus.Count);
        end
        base = enable_cnt;
        push_byte(8'h5A, 1'b1);
        wait_ready_high(60, "rst_mid");
        checks++;
        if (enable_cnt != base) begin
            failures++;
            $display("FAIL rst_mid_early_enable got=%0d required=0", enable_cnt - base);
        end
        wait_idle(100, "rst_mid");
        checks++;
        if (last_sent !== 8'h5A || enable_cnt - base != 1) begin
            failures++;
            $display("FAIL rst_mid_resume got last=%02h sent=%0d required 5a/1", last_sent, enable_cnt - base);
        end
        tx_busy_len = 10;
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst          = 1'b1;
        bus.Wr_Data  = 8'h00;
        bus.Wr_En    = 1'b0;
        bus.Flush    = 1'b0;
        bus.Tx_Ready = 1'b1;

        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_wrap_full_pop();
        test_flush();
        test_timeout();
        test_reset_midframe();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
